nios2_jtag_sysclk_cmd_bridge: RTL and testbench
===============================================

Name: nios2_jtag_sysclk_cmd_bridge

Overview:
Parametrised system-clock side of the Nios II JTAG debug module. It receives JTAG data-register updates from the TCK domain through a toggle handshake and resynchronises them into clk. Each update is buffered as an {IR, DR} command in a small FIFO, then handed to the OCI core through a valid/ready interface. On hand-off it produces one-hot take_action / take_no_action pulses per IR channel. This generalises the fixed 2-bit-IR, 38-bit, unbuffered sysclk stage to any IR/DR width, adds buffering and adds overflow accounting.

Parameters:
IR_W, 2, JTAG instruction width; channel count is 2**IR_W
DR_W, 38, data register / jdo width
DEPTH, 4, command FIFO depth; power of 2, >=2
SYNC_STAGES, 2, synchroniser flops on upd_toggle; >=2
ACTION_BIT, 37, DR bit that selects take_action (1) vs take_no_action (0); < DR_W
CNT_W, 8, drop counter width

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
upd_toggle  in  1  TCK-domain toggle; flips once per DR update
ir_in  in  IR_W  TCK-domain IR; quasi-static between toggles
sr  in  DR_W  TCK-domain shift register; quasi-static between toggles
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts head
cmd_ir  out  IR_W  head IR
jdo  out  DR_W  head DR
take_action  out  2**IR_W  one-cycle pulse, bit cmd_ir, on accept with jdo[ACTION_BIT]=1
take_no_action  out  2**IR_W  one-cycle pulse, bit cmd_ir, on accept with jdo[ACTION_BIT]=0
fifo_level  out  clog2(DEPTH)+1  entries held
overflow  out  1  sticky: an update was dropped
drop_count  out  CNT_W  saturating count of dropped updates
clr_overflow  in  1  clears overflow and drop_count

Behaviour:
- Reset (async assert, sync-to-clk release): sync chain, edge flop, arm counter, FIFO pointers, and every output forced to 0. This covers cmd_valid, cmd_ir, jdo, take_*, fifo_level, overflow and drop_count.
- Sync: sync[0] samples upd_toggle and the chain shifts each clk. The edge flop prev holds last sync[SYNC_STAGES-1]. The event is sync[SYNC_STAGES-1] ^ prev.
- Arming: after reset release the arm counter counts SYNC_STAGES+1 cycles. Until it saturates, prev tracks the chain and events are suppressed, so an upd_toggle already at 1 out of reset produces no command.
- Push: on event, ir_in and sr are sampled at that clk edge and written to the FIFO tail. This is the same edge at which prev updates.
- Latency: a toggle first sampled at edge k gives cmd_valid=1 after edge k+SYNC_STAGES, when the FIFO was empty. There is no extra bypass.
- Pop: occurs on the edge where cmd_valid & cmd_ready. On that same edge, take_action[cmd_ir] or take_no_action[cmd_ir] goes high for exactly one cycle, selected by jdo[ACTION_BIT]. All other bits stay 0. Head outputs advance to the next entry, or hold their last value with cmd_valid=0 when emptied.
- jdo/cmd_ir are don't-care while cmd_valid=0. They must remain stable while cmd_valid=1 and cmd_ready=0.
- Full: push while level==DEPTH with no pop in the same cycle drops the command, sets overflow and increments drop_count. drop_count saturates at 2**CNT_W-1.
- Simultaneous push and pop when full: accepted, no drop, level unchanged.
- Simultaneous push and pop when empty: only the push takes effect, because cmd_valid was 0 so no pop occurs.
- clr_overflow coincident with a drop: the drop wins. overflow=1 and drop_count=1.
- fifo_level: +1 push, -1 pop, unchanged for both or neither. It is never >DEPTH.
- TCK-side contract: sr/ir_in stay stable from the toggle until at least SYNC_STAGES+2 clk later. Toggles are spaced >= SYNC_STAGES+2 clk apart. Closer spacing is outside contract.
- Reset mid-operation: FIFO contents are discarded, and no take_* pulse is emitted during or after reset for pre-reset commands.

Test Plan:
1. Defaults, cmd_ready=1. Toggle 0->1 with ir_in=2, sr=38'h20_0000_1234 (bit37=1). Required: cmd_valid high exactly 3 edges after first sampling; jdo=38'h20_0000_1234; take_action=4'b0100 for 1 cycle; take_no_action=0.
2. cmd_ready=0, 5 toggles. Required: fifo_level reaches 4; 5th toggle gives overflow=1, drop_count=1. Then cmd_ready=1 drains 4 entries in order, with 4 pulses on consecutive cycles.
3. Full FIFO, pop and toggle event in the same cycle. Required: no drop; level stays 4; new entry appears last.
4. Hold upd_toggle=1 through reset release. Required: no cmd_valid for 20 cycles. A subsequent toggle 1->0 produces exactly one command.
5. Drop and clr_overflow in the same cycle. Required: overflow=1, drop_count=1. Then clr_overflow alone gives 0/0. 300 drops give drop_count=255.
6. Assert reset with 3 entries queued. Required: all outputs 0 asynchronously; after release no pulses and fifo_level=0.

Source files
------------

// File: rtl/nios2_jtag_sysclk_cmd_bridge_if.sv
// Command hand-off bundle between the JTAG sysclk bridge and the OCI core.
//   master (bridge): drives cmd_valid, cmd_ir, jdo, take_action, take_no_action
//   slave  (core)  : drives cmd_ready
interface nios2_jtag_sysclk_cmd_bridge_if #(
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38
);
  localparam int unsigned CH = 1 << IR_W;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] jdo;
  logic [CH-1:0]   take_action;
  logic [CH-1:0]   take_no_action;

  modport master (
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/nios2_jtag_sysclk_cmd_bridge.sv
// System-clock side of the Nios II JTAG debug module.
// Resynchronises the TCK-domain DR-update toggle, buffers each {IR, DR}
// update in a small FIFO and hands it to the OCI core over valid/ready,
// pulsing take_action / take_no_action one-hot on the accepted IR channel.
// Ports:
//   clk, reset          system clock, async active-high reset
//   upd_toggle          TCK-domain toggle, flips once per DR update
//   ir_in, sr           TCK-domain IR and shift register (quasi-static)
//   cmd                 command hand-off (valid/ready, head IR/DR, pulses)
//   fifo_level          entries currently buffered
//   overflow            sticky flag: an update was dropped
//   drop_count          saturating count of dropped updates
//   clr_overflow        clears overflow and drop_count
module nios2_jtag_sysclk_cmd_bridge #(
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DR_W        = 38,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACTION_BIT  = 37,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          upd_toggle,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DR_W-1:0]               sr,
  nios2_jtag_sysclk_cmd_bridge_if.master cmd,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count,
  input  logic                          clr_overflow
);
  localparam int unsigned CH    = 1 << IR_W;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned EW    = IR_W + DR_W;
  localparam int unsigned ARM_N = SYNC_STAGES + 1;
  localparam int unsigned ARM_W = $clog2(ARM_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ARM_W-1:0]       arm_cnt;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [EW-1:0]          mem [DEPTH];

  logic           armed;
  logic           evt;
  logic           pop;
  logic           full;
  logic           push_ok;
  logic           drop;
  logic [AW-1:0]  rd_n;
  logic [LW-1:0]  level_n;
  logic [EW-1:0]  head_n;

  // Next-state for the FIFO and head registers
  always_comb begin
    armed   = (arm_cnt == ARM_W'(ARM_N));
    evt     = armed && (sync_q[SYNC_STAGES-1] ^ prev_q);
    pop     = cmd.cmd_valid && cmd.cmd_ready;
    full    = (fifo_level == LW'(DEPTH));
    push_ok = evt && (!full || pop);
    drop    = evt && !push_ok;
    rd_n    = pop ? AW'(rd_ptr + AW'(1)) : rd_ptr;
    level_n = fifo_level + LW'(push_ok) - LW'(pop);
    head_n  = mem[rd_n];
    // Entry being written this edge becomes the head when nothing older remains
    if (push_ok && (fifo_level == LW'(pop))) begin
      head_n = {ir_in, sr};
    end
  end

  // FIFO storage; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {ir_in, sr};
    end
  end

  // Synchroniser, arming, pointers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q             <= '0;
      prev_q             <= 1'b0;
      arm_cnt            <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      fifo_level         <= '0;
      overflow           <= 1'b0;
      drop_count         <= '0;
      cmd.cmd_valid      <= 1'b0;
      cmd.cmd_ir         <= '0;
      cmd.jdo            <= '0;
      cmd.take_action    <= '0;
      cmd.take_no_action <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], upd_toggle};
      // prev tracks the chain even while unarmed so a static level is absorbed
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_W'(1);
      end

      if (pop)     rd_ptr <= rd_n;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      fifo_level <= level_n;

      cmd.cmd_valid <= (level_n != '0);
      if (level_n != '0) begin
        {cmd.cmd_ir, cmd.jdo} <= head_n;
      end

      cmd.take_action    <= '0;
      cmd.take_no_action <= '0;
      if (pop) begin
        if (cmd.jdo[ACTION_BIT]) cmd.take_action    <= CH'(1) << cmd.cmd_ir;
        else                     cmd.take_no_action <= CH'(1) << cmd.cmd_ir;
      end

      // A drop outranks a coincident clear
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clr_overflow ? CNT_W'(1)
                    : (drop_count == CNT_MAX) ? CNT_MAX
                    : drop_count + CNT_W'(1);
      end else if (clr_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_nios2_jtag_sysclk_cmd_bridge.sv
module tb_nios2_jtag_sysclk_cmd_bridge;
  typedef struct {
    logic [1:0]  ir;
    logic [37:0] dr;
    logic [3:0]  ta;
    logic [3:0]  tna;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        upd_toggle;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clr_overflow;

  nios2_jtag_sysclk_cmd_bridge_if #(.IR_W(2), .DR_W(38)) cmd_if ();

  nios2_jtag_sysclk_cmd_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .upd_toggle   (upd_toggle),
    .ir_in        (ir_in),
    .sr           (sr),
    .cmd          (cmd_if),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  vec_t sb[$];
  vec_t vecs[7];
  logic [3:0] exp_ta  = '0;
  logic [3:0] exp_tna = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic vec_t mk(input logic [1:0] ir, input logic [37:0] dr);
    vec_t v;
    v.ir  = ir;
    v.dr  = dr;
    v.ta  = dr[37] ? (4'b0001 << ir) : 4'b0000;
    v.tna = dr[37] ? 4'b0000 : (4'b0001 << ir);
    return v;
  endfunction

  function automatic logic [37:0] rnd_dr();
    return {6'($urandom_range(0, 63)), 32'($urandom)};
  endfunction

  // Flip the toggle with a new {IR, DR}; accepted commands go to the scoreboard
  task automatic send(input vec_t v, input bit accept);
    ir_in      = v.ir;
    sr         = v.dr;
    upd_toggle = ~upd_toggle;
    if (accept) sb.push_back(v);
  endtask

  // Checks head contents and one-hot pulses against the scoreboard
  always @(negedge clk) begin
    vec_t e;
    if (reset) begin
      exp_ta  = '0;
      exp_tna = '0;
    end
    chk("take_action", 64'(cmd_if.take_action), 64'(exp_ta));
    chk("take_no_action", 64'(cmd_if.take_no_action), 64'(exp_tna));
    exp_ta  = '0;
    exp_tna = '0;
    if (!reset && cmd_if.cmd_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got ir=%0h jdo=%0h want none", cmd_if.cmd_ir, cmd_if.jdo);
      end else begin
        e = sb[0];
        chk("head_jdo", 64'(cmd_if.jdo), 64'(e.dr));
        chk("head_ir", 64'(cmd_if.cmd_ir), 64'(e.ir));
        if (cmd_if.cmd_ready) begin
          void'(sb.pop_front());
          exp_ta  = e.ta;
          exp_tna = e.tna;
          pops++;
        end
      end
    end
  end

  initial begin
    int cnt;
    int p0;
    vec_t v;

    vecs[0] = '{2'd2, 38'h20_0000_1234, 4'b0100, 4'b0000};
    vecs[1] = '{2'd0, 38'h00_0000_0001, 4'b0000, 4'b0001};
    vecs[2] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
    vecs[3] = '{2'd1, 38'h1F_FFFF_FFFF, 4'b0000, 4'b0010};
    vecs[4] = '{2'd3, 38'h00_0000_0000, 4'b0000, 4'b1000};
    vecs[5] = '{2'd1, 38'h20_0000_0000, 4'b0010, 4'b0000};
    vecs[6] = '{2'd0, 38'h2A_AAAA_5555, 4'b0001, 4'b0000};

    reset            = 1'b1;
    upd_toggle       = 1'b0;
    ir_in            = '0;
    sr               = '0;
    clr_overflow     = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    steps(2);

    // Reset state
    chk("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("rst_jdo", 64'(cmd_if.jdo), 64'd0);
    chk("rst_ir", 64'(cmd_if.cmd_ir), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    reset = 1'b0;
    steps(6);

    // Latency of the first command: valid after the third sampling edge
    send(vecs[0], 1'b1);
    step();
    chk("lat_e1", 64'(cmd_if.cmd_valid), 64'd0);
    step();
    chk("lat_e2", 64'(cmd_if.cmd_valid), 64'd0);
    step();
    chk("lat_e3", 64'(cmd_if.cmd_valid), 64'd1);
    chk("lat_jdo", 64'(cmd_if.jdo), 64'h20_0000_1234);
    step();
    chk("lat_single", 64'(cmd_if.cmd_valid), 64'd0);
    steps(3);

    // Table of commands, consumer always ready
    for (int i = 1; i < 7; i++) begin
      send(vecs[i], 1'b1);
      steps(4);
    end
    steps(3);
    chk("tbl_sb_empty", 64'(sb.size()), 64'd0);
    chk("tbl_level", 64'(fifo_level), 64'd0);

    // Fill with consumer stalled; fifth update is dropped
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(mk(2'(i), rnd_dr()), i < 4);
      steps(4);
      if (i == 3) begin
        chk("fill_level4", 64'(fifo_level), 64'd4);
        chk("fill_no_ovf", 64'(overflow), 64'd0);
      end
    end
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd1);
    cmd_if.cmd_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt += $countones({cmd_if.take_action, cmd_if.take_no_action});
    end
    chk("drain_pulses", 64'(cnt), 64'd4);
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // Full FIFO: pop and push on the same edge
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(mk(2'(3 - i), rnd_dr()), 1'b1);
      steps(4);
    end
    chk("pp_pre_level", 64'(fifo_level), 64'd4);
    send(mk(2'd1, 38'h25_DEAD_BEEF), 1'b1);
    steps(2);
    cmd_if.cmd_ready = 1'b1;
    step();
    cmd_if.cmd_ready = 1'b0;
    chk("pp_level", 64'(fifo_level), 64'd4);
    chk("pp_drops", 64'(drop_count), 64'd1);
    step();
    chk("pp_level_hold", 64'(fifo_level), 64'd4);
    cmd_if.cmd_ready = 1'b1;
    steps(8);
    chk("pp_drain_level", 64'(fifo_level), 64'd0);
    chk("pp_drain_sb", 64'(sb.size()), 64'd0);

    // Overflow clear, drop-vs-clear priority, saturation
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drops", 64'(drop_count), 64'd0);
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(mk(2'(i), rnd_dr()), 1'b1);
      steps(4);
    end
    send(mk(2'd0, rnd_dr()), 1'b0);
    steps(2);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("dropclr_ovf", 64'(overflow), 64'd1);
    chk("dropclr_drops", 64'(drop_count), 64'd1);
    step();
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("clr2_ovf", 64'(overflow), 64'd0);
    chk("clr2_drops", 64'(drop_count), 64'd0);
    for (int i = 0; i < 300; i++) begin
      send(mk(2'(i), rnd_dr()), 1'b0);
      steps(4);
    end
    chk("sat_drops", 64'(drop_count), 64'd255);
    chk("sat_ovf", 64'(overflow), 64'd1);
    chk("sat_level", 64'(fifo_level), 64'd4);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    steps(8);
    chk("sat_drain_sb", 64'(sb.size()), 64'd0);

    // Toggle held high through reset release produces nothing
    reset      = 1'b1;
    upd_toggle = 1'b1;
    steps(3);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_if.cmd_valid) cnt++;
    end
    chk("arm_no_valid", 64'(cnt), 64'd0);
    p0 = pops;
    send(mk(2'd2, 38'h01_2345_6789), 1'b1);
    steps(10);
    chk("arm_one_cmd", 64'(pops - p0), 64'd1);
    chk("arm_sb", 64'(sb.size()), 64'd0);

    // Reset with queued entries discards them
    cmd_if.cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(mk(2'(i + 1), 38'h20_0000_0000 | 38'(i)), 1'b1);
      steps(4);
    end
    chk("mid_level3", 64'(fifo_level), 64'd3);
    chk("mid_valid", 64'(cmd_if.cmd_valid), 64'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("arst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("arst_jdo", 64'(cmd_if.jdo), 64'd0);
    chk("arst_ir", 64'(cmd_if.cmd_ir), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ta", 64'(cmd_if.take_action), 64'd0);
    chk("arst_tna", 64'(cmd_if.take_no_action), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_drops", 64'(drop_count), 64'd0);
    steps(2);
    reset = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    p0 = pops;
    steps(15);
    chk("post_rst_level", 64'(fifo_level), 64'd0);
    chk("post_rst_pops", 64'(pops - p0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
